pcm_echo_delay: RTL and testbench

Parametrised, strobe-driven delay line for signed PCM samples, built on a circular buffer. It is the successor to the fixed shift-register delay.
- Adds per-sample advance strobe, output-valid pulse and runtime delay select up to DEPTH samples.
- Masks stale buffer contents after reset via a fill counter.
- Adds an optional saturating feedback path (comb echo).
- Sits between the PCM source and the output mixer/DAC path.

---
 rtl/pcm_echo_delay.sv | 82 ++++++++
 tb/tb_pcm_echo_delay.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pcm_echo_delay.sv
// Strobe-driven circular-buffer delay line for signed PCM with fill masking.
// Define ECHO_FEEDBACK_EN to add the saturating comb-echo feedback path.
module pcm_echo_delay #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [ADDR_W-1:0]        delay,
  input  logic [2:0]               fb_shift,
  input  logic signed [DATA_W-1:0] pcm_in,
  output logic signed [DATA_W-1:0] pcm_out,
  output logic                     out_valid
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_F = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   FULL  = (ADDR_W + 1)'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W:0]          fill;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     masked;
  logic signed [DATA_W-1:0] tap_p0;
  logic signed [DATA_W-1:0] wdata_p0;

  // Stage 0: pre-write read of the tap; slots not yet written since reset read as zero
  assign rd_addr = wr_ptr - delay - ONE_A;
  assign masked  = fill < ({1'b0, delay} + ONE_F);
  assign tap_p0  = masked ? '0 : mem[rd_addr];

`ifdef ECHO_FEEDBACK_EN
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    // Overflow iff the guard bit disagrees with the sign bit of the narrowed result
    if (v[DATA_W] != v[DATA_W-1])
      sat = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat = v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] fb_p0;
  logic signed [DATA_W:0]   sum_p0;

  always_comb begin
    fb_p0 = '0;
    if (fb_shift != 3'd0)
      fb_p0 = tap_p0 >>> fb_shift;
    sum_p0 = $signed({pcm_in[DATA_W-1], pcm_in}) + $signed({fb_p0[DATA_W-1], fb_p0});
  end

  assign wdata_p0 = sat(sum_p0);
`else
  logic unused_fb;
  assign unused_fb = ^fb_shift;
  assign wdata_p0  = pcm_in;
`endif

  always_ff @(posedge clk) begin
    if (sample_en && !rst)
      mem[wr_ptr] <= wdata_p0;
  end

  // Stage 1: registered output and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      pcm_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_en;
      if (sample_en) begin
        wr_ptr  <= wr_ptr + ONE_A;
        pcm_out <= tap_p0;
        if (fill != FULL)
          fill <= fill + ONE_F;
      end
    end
  end
endmodule

// File: tb/tb_pcm_echo_delay.sv
// Scoreboard bench for pcm_echo_delay: behavioural sample-history model feeds an expected queue.
// Build with ECHO_FEEDBACK_EN defined to exercise the feedback path in both DUT and model.
module tb_pcm_echo_delay;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int MAXV   = (1 << (DATA_W - 1)) - 1;
  localparam int MINV   = -(1 << (DATA_W - 1));

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     sample_en = 1'b0;
  logic [ADDR_W-1:0]        delay = '0;
  logic [2:0]               fb_shift = '0;
  logic signed [DATA_W-1:0] pcm_in = '0;
  logic signed [DATA_W-1:0] pcm_out;
  logic                     out_valid;

  pcm_echo_delay #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .delay(delay),
    .fb_shift(fb_shift), .pcm_in(pcm_in), .pcm_out(pcm_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int hist[$];
  bit started = 1'b0;
  int last_out = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference: w[] is the list of values written since reset; tap is w[n-d-1] if it exists.
  function automatic int model_strobe(input int x, input int d, input int fs);
    int n, tap, w;
    n = hist.size();
    tap = (n >= d + 1) ? hist[n - d - 1] : 0;
    w = x;
`ifdef ECHO_FEEDBACK_EN
    if (fs != 0) w = x + (tap >>> fs);
    if (w > MAXV) w = MAXV;
    if (w < MINV) w = MINV;
`endif
    hist.push_back(w);
    return tap;
  endfunction

  task automatic strobe(input int x, input int d, input int fs);
    rst = 1'b0;
    sample_en = 1'b1;
    pcm_in = x[DATA_W-1:0];
    delay = d[ADDR_W-1:0];
    fb_shift = fs[2:0];
    exp_q.push_back(model_strobe(x, d, fs));
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    int junk;
    for (int i = 0; i < k; i++) begin
      rst = 1'b0;
      sample_en = 1'b0;
      junk = int'($urandom);
      pcm_in = junk[DATA_W-1:0];
      delay = junk[ADDR_W+7:8];
      fb_shift = junk[14:12];
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input bit en);
    rst = 1'b1;
    sample_en = en;
    pcm_in = 19'h1234;
    hist.delete();
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b0;
  endtask

  function automatic int rnd_pcm();
    return int'($urandom_range(0, 2 * MAXV + 1)) + MINV;
  endfunction

  // Monitor: one check per cycle, 1 time unit after the rising edge
  initial begin
    bit rst_s;
    int want;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        started = 1'b1;
        last_out = 0;
        check("reset_valid", int'(out_valid), 0);
        check("reset_out", int'(pcm_out), 0);
      end else if (started) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            want = exp_q.pop_front();
            check("pcm_out", int'(pcm_out), want);
            last_out = want;
          end
        end else begin
          check("hold_out", int'(pcm_out), last_out);
        end
      end
    end
  end

  initial begin
    int x;
    @(negedge clk);
    do_reset(1'b0);

    // Pure delay, minimum tap
    for (int i = 1; i <= 40; i++) strobe(i, 0, 0);
    idle(2);

    // Maximum delay with gaps and junk on inputs between strobes
    do_reset(1'b0);
    for (int n = 0; n < 45; n++) begin
      strobe(100 + n, DEPTH - 1, 0);
      idle(2);
    end

    // Echo impulse
    do_reset(1'b0);
    strobe(1000, 3, 1);
    for (int n = 1; n < 24; n++) strobe(0, 3, 1);
    idle(1);

    // Saturation at both rails
    do_reset(1'b0);
    for (int n = 0; n < 20; n++) strobe(MAXV, 0, 1);
    do_reset(1'b0);
    for (int n = 0; n < 20; n++) strobe(MINV, 0, 1);
    idle(1);

    // Reset mid-stream with strobe high: stale memory must stay hidden
    do_reset(1'b0);
    for (int n = 0; n < 40; n++) strobe(32'h1234, 5, 0);
    do_reset(1'b1);
    for (int n = 0; n < 10; n++) strobe(rnd_pcm(), 5, 0);
    idle(1);

    // Delay change at n=20
    do_reset(1'b0);
    for (int n = 0; n < 30; n++) strobe(n + 1, (n < 20) ? 7 : 2, 0);
    idle(1);

    // Randomised traffic with occasional resets
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      x = int'($urandom_range(0, 99));
      if (x < 2) do_reset(x[0]);
      else if (x < 70) strobe(rnd_pcm(), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)));
      else idle(1);
    end
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
